// File: rtl/usb_fx2_pkg.sv
// rtl/usb_fx2_pkg.sv - FX2LP slave-FIFO bridge shared types, endpoint defaults and strobe levels
package usb_fx2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEL_RD = 3'd1,
        ST_RD     = 3'd2,
        ST_SEL_WR = 3'd3,
        ST_WR     = 3'd4,
        ST_TURN   = 3'd5,
        ST_PEND   = 3'd6
    } fx2_state_t;

    localparam logic [1:0] EP_OUT_ADR_DEF = 2'b00;
    localparam logic [1:0] EP_IN_ADR_DEF  = 2'b10;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/usb_rx_fifo.sv
// rtl/usb_rx_fifo.sv - synchronous RX buffer with empty flag and free-entry count
module usb_rx_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [DW-1:0]              i_data,
    input  logic                       i_pop,
    output logic [DW-1:0]              o_data,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_free
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign w_push_ok = i_push && (r_count != DEPTH_W);
    assign w_pop_ok  = i_pop && (r_count != '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_empty   = (r_count == '0);
    assign o_free    = DEPTH_W - r_count;

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and level bookkeeping; reset flushes the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The read side of the bridge must never push into a full buffer.
    always @(posedge clk) begin
        if (rst_n && i_push) begin
            assert (r_count != DEPTH_W);
        end
    end

endmodule

// File: rtl/usb_fifo_bridge.sv
// rtl/usb_fifo_bridge.sv - FX2LP slave-FIFO master bridging EP2 OUT / EP6 IN to rx/tx streams (option: USB_PKTEND_EN)
module usb_fifo_bridge
    import usb_fx2_pkg::*;
#(
    parameter int         DW         = 16,
    parameter int         RX_DEPTH   = 8,
    parameter int         BURST_MAX  = 64,
    parameter logic [1:0] EP_OUT_ADR = EP_OUT_ADR_DEF,
    parameter logic [1:0] EP_IN_ADR  = EP_IN_ADR_DEF
`ifdef USB_PKTEND_EN
    ,
    parameter int         PKT_WORDS  = 256
`endif
) (
    input  logic          CLKOUT,
    input  logic          rst_n,
    input  logic          FLAGA,
    input  logic          FLAGD,
    output logic          SLRD,
    output logic          SLWR,
    output logic          SLOE,
    output logic          IFCLK,
    output logic [1:0]    FIFOADR,
    inout  wire  [DW-1:0] FD,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [31:0]   rd_words,
    output logic [31:0]   wr_words
`ifdef USB_PKTEND_EN
    ,
    input  logic          tx_last,
    output logic          PKTEND
`endif
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [AW:0]   FREE_MIN  = (AW+1)'(2);
    localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

    fx2_state_t    r_state;
    fx2_state_t    w_state_nxt;
    logic [BW-1:0] r_burst;
    logic          r_last_rd;
    logic [1:0]    r_fifoadr;
    logic [31:0]   r_rd_words;
    logic [31:0]   r_wr_words;

    logic          w_slrd;
    logic          w_slwr;
    logic          w_sloe;
    logic          w_fd_oe;
    logic          w_tx_ready;
    logic          w_push;
    logic          w_burst_inc;
    logic          w_pktend;
    logic          w_rx_empty;
    logic [AW:0]   w_free;
    logic          w_free_ok;
    logic          w_rd_req;
    logic          w_wr_req;
    logic          w_rd_go;
    logic          w_wr_go;

`ifdef USB_PKTEND_EN
    localparam int PW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [PW-1:0] PKT_LAST = PW'(PKT_WORDS - 1);
    logic [PW-1:0] r_pkt_cnt;
    logic [PW-1:0] w_pkt_nxt;
    assign w_pkt_nxt = (r_pkt_cnt == PKT_LAST) ? '0 : r_pkt_cnt + 1'b1;
`endif

    // Two free entries are required so a word already on FD can always land.
    assign w_free_ok = (w_free >= FREE_MIN);
    assign w_rd_req  = FLAGA && w_free_ok;
    assign w_wr_req  = tx_valid && FLAGD;
    assign w_rd_go   = w_rd_req && (r_burst < BURST_LIM);
    assign w_wr_go   = w_wr_req && (r_burst < BURST_LIM);

    usb_rx_fifo #(
        .DW    (DW),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (CLKOUT),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (FD),
        .i_pop   (rx_valid && rx_ready),
        .o_data  (rx_data),
        .o_empty (w_rx_empty),
        .o_free  (w_free)
    );

    assign rx_valid = !w_rx_empty;
    assign tx_ready = w_tx_ready;
    assign SLRD     = w_slrd;
    assign SLWR     = w_slwr;
    assign SLOE     = w_sloe;
    assign IFCLK    = ~CLKOUT;
    assign FIFOADR  = r_fifoadr;
    assign rd_words = r_rd_words;
    assign wr_words = r_wr_words;
    assign FD       = w_fd_oe ? tx_data : {DW{1'bz}};
`ifdef USB_PKTEND_EN
    assign PKTEND   = w_pktend;
`endif

    // Next state and bus strobes; strobes follow the live flags so tx_ready and SLWR agree in-cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_slrd      = STROBE_OFF;
        w_slwr      = STROBE_OFF;
        w_sloe      = STROBE_OFF;
        w_fd_oe     = 1'b0;
        w_tx_ready  = 1'b0;
        w_push      = 1'b0;
        w_burst_inc = 1'b0;
        w_pktend    = STROBE_OFF;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_req && (!w_wr_req || !r_last_rd)) w_state_nxt = ST_SEL_RD;
                else if (w_wr_req)                         w_state_nxt = ST_SEL_WR;
            end
            ST_SEL_RD: begin
                w_sloe      = STROBE_ON;
                w_state_nxt = ST_RD;
            end
            ST_RD: begin
                w_sloe = STROBE_ON;
                if (w_rd_go) begin
                    w_slrd      = STROBE_ON;
                    w_push      = 1'b1;
                    w_burst_inc = 1'b1;
                end else begin
                    w_state_nxt = ST_TURN;
                end
            end
            ST_SEL_WR: begin
                w_fd_oe     = 1'b1;
                w_state_nxt = ST_WR;
            end
            ST_WR: begin
                w_fd_oe = 1'b1;
                if (w_wr_go) begin
                    w_slwr      = STROBE_ON;
                    w_tx_ready  = 1'b1;
                    w_burst_inc = 1'b1;
`ifdef USB_PKTEND_EN
                    if (tx_last && (w_pkt_nxt != '0)) w_state_nxt = ST_PEND;
`endif
                end else begin
                    w_state_nxt = ST_TURN;
                end
            end
`ifdef USB_PKTEND_EN
            ST_PEND: begin
                w_fd_oe     = 1'b1;
                w_pktend    = STROBE_ON;
                w_state_nxt = ST_TURN;
            end
`endif
            ST_TURN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, burst length, endpoint select, round-robin memory and word counters.
    always_ff @(posedge CLKOUT or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_burst    <= '0;
            r_last_rd  <= 1'b0;
            r_fifoadr  <= EP_OUT_ADR;
            r_rd_words <= '0;
            r_wr_words <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_TURN)  r_burst <= '0;
            else if (w_burst_inc)    r_burst <= r_burst + 1'b1;
            if (r_state == ST_IDLE) begin
                if (w_state_nxt == ST_SEL_RD) begin
                    r_fifoadr <= EP_OUT_ADR;
                    r_last_rd <= 1'b1;
                end else if (w_state_nxt == ST_SEL_WR) begin
                    r_fifoadr <= EP_IN_ADR;
                    r_last_rd <= 1'b0;
                end
            end
            if (w_push)     r_rd_words <= r_rd_words + 32'd1;
            if (w_tx_ready) r_wr_words <= r_wr_words + 32'd1;
        end
    end

`ifdef USB_PKTEND_EN
    // Position within the current IN packet; a message end restarts the count.
    always_ff @(posedge CLKOUT or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_cnt <= '0;
        end else if (w_tx_ready) begin
            r_pkt_cnt <= tx_last ? '0 : w_pkt_nxt;
        end
    end
`endif

    // The FX2 drives FD whenever SLOE is low, so the bridge must never drive it then.
    always @(posedge CLKOUT) begin
        if (rst_n) begin
            assert (!(w_fd_oe && (w_sloe == STROBE_ON)));
        end
    end

endmodule

// File: tb/tb_usb_fifo_bridge.sv
// tb/tb_usb_fifo_bridge.sv - scoreboard bench for usb_fifo_bridge with an FX2 slave-FIFO model
module tb_usb_fifo_bridge;

    localparam int DW = 16;

    logic          CLKOUT   = 1'b0;
    logic          rst_n    = 1'b0;
    logic          FLAGA    = 1'b0;
    logic          FLAGD    = 1'b0;
    logic          rx_ready = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data  = '0;
    logic [DW-1:0] fx_data  = '0;
    wire           SLRD, SLWR, SLOE, IFCLK;
    wire  [1:0]    FIFOADR;
    wire  [DW-1:0] FD;
    wire  [DW-1:0] rx_data;
    wire           rx_valid, tx_ready;
    wire  [31:0]   rd_words, wr_words;
`ifdef USB_PKTEND_EN
    logic          tx_last = 1'b0;
    wire           PKTEND;
`endif

    logic [DW-1:0] out_q  [$];
    logic [DW-1:0] rx_exp [$];
    logic [DW-1:0] tx_exp [$];
    logic [DW:0]   tx_src [$];
    int            runs   [$];
    int in_cnt   = 0;
    int in_limit = 1000000;
    int passed = 0, total = 0;
    int conflicts = 0, addr_err = 0, rdy_err = 0, hs_err = 0, pkt_pulses = 0;
    int cur_r = 0, cur_w = 0;
    int base;

    assign FD = (!SLOE) ? fx_data : {DW{1'bz}};

    always #5 CLKOUT = ~CLKOUT;

    usb_fifo_bridge #(
        .DW        (DW),
        .RX_DEPTH  (8),
        .BURST_MAX (64)
    ) dut (
        .CLKOUT   (CLKOUT),
        .rst_n    (rst_n),
        .FLAGA    (FLAGA),
        .FLAGD    (FLAGD),
        .SLRD     (SLRD),
        .SLWR     (SLWR),
        .SLOE     (SLOE),
        .IFCLK    (IFCLK),
        .FIFOADR  (FIFOADR),
        .FD       (FD),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rd_words (rd_words),
        .wr_words (wr_words)
`ifdef USB_PKTEND_EN
        ,
        .tx_last  (tx_last),
        .PKTEND   (PKTEND)
`endif
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic send_rx(input int b, input int n);
        for (int i = 0; i < n; i++) begin
            out_q.push_back(DW'(b + i));
            rx_exp.push_back(DW'(b + i));
        end
    endtask

    task automatic send_tx(input int b, input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] d;
            d = DW'(b + i);
            tx_src.push_back({last && (i == n - 1), d});
            tx_exp.push_back(d);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((rx_exp.size() != 0 || tx_exp.size() != 0) && n < budget) begin
            @(posedge CLKOUT);
            n++;
        end
        if (n >= budget) check({name, "_timeout"}, rx_exp.size() + tx_exp.size(), 0);
        repeat (6) @(posedge CLKOUT);
        #2;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLKOUT);
        #2;
    endtask

    function automatic int run_at(input int idx);
        return (idx < runs.size()) ? runs[idx] : -9999;
    endfunction

    // FX2 model, tx source and scoreboard monitor: sample at negedge, advance just after posedge.
    always begin : fx2_model
        logic rd_f, wr_f, tx_f, rx_f;
        @(negedge CLKOUT);
        rd_f = rst_n && !SLRD && FLAGA;
        wr_f = rst_n && !SLWR;
        tx_f = tx_valid && tx_ready;
        rx_f = rx_valid && rx_ready;
        if (rx_f) begin
            if (rx_exp.size() == 0) check("rx_unexpected", 1, 0);
            else check("rx_data", rx_data, rx_exp.pop_front());
        end
        if (wr_f) begin
            if (tx_exp.size() == 0) check("in_unexpected", 1, 0);
            else check("in_data", FD, tx_exp.pop_front());
        end
        if (rst_n && (wr_f != tx_f)) hs_err++;
        if (!SLOE && dut.w_fd_oe) conflicts++;
        if (!SLRD && FIFOADR != 2'b00) addr_err++;
        if (!SLWR && FIFOADR != 2'b10) addr_err++;
        if (tx_ready && !FLAGD) rdy_err++;
        if (rd_f) cur_r++;
        else if (cur_r > 0) begin runs.push_back(cur_r); cur_r = 0; end
        if (wr_f) cur_w++;
        else if (cur_w > 0) begin runs.push_back(-cur_w); cur_w = 0; end
`ifdef USB_PKTEND_EN
        if (rst_n && !PKTEND) pkt_pulses++;
`endif
        @(posedge CLKOUT);
        #1;
        if (rd_f) void'(out_q.pop_front());
        if (wr_f) in_cnt++;
        if (tx_f) void'(tx_src.pop_front());
        FLAGA    = out_q.size() > 0;
        FLAGD    = in_cnt < in_limit;
        fx_data  = (out_q.size() > 0) ? out_q[0] : '0;
        tx_valid = tx_src.size() > 0;
        tx_data  = (tx_src.size() > 0) ? tx_src[0][DW-1:0] : '0;
`ifdef USB_PKTEND_EN
        tx_last  = (tx_src.size() > 0) ? tx_src[0][DW] : 1'b0;
`endif
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cycles(3);
        check("rst_slrd", SLRD, 1);
        check("rst_slwr", SLWR, 1);
        check("rst_sloe", SLOE, 1);
        check("rst_fifoadr", FIFOADR, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rd_words", rd_words, 0);
        check("rst_wr_words", wr_words, 0);
        check("ifclk", IFCLK, !CLKOUT);
        rst_n = 1'b1;
        cycles(3);

        // Five queued OUT words with a ready consumer.
        rx_ready = 1'b1;
        runs.delete();
        send_rx(16'h1000, 5);
        drain("t1", 200);
        check("t1_rd_words", rd_words, 5);
        check("t1_run", run_at(0), 5);
        check("t1_runs", runs.size(), 1);
        check("t1_idle_sloe", SLOE, 1);

        // Consumer stalled: reads stop with seven buffered, resume on ready.
        rx_ready = 1'b0;
        send_rx(16'h2000, 20);
        cycles(40);
        check("t2_rd_stall", rd_words, 12);
        check("t2_rx_valid", rx_valid, 1);
        check("t2_slrd_idle", SLRD, 1);
        rx_ready = 1'b1;
        drain("t2", 400);
        check("t2_rd_words", rd_words, 25);

        // 100 IN words split by the burst limit.
        runs.delete();
        send_tx(16'h3000, 100, 1'b0);
        drain("t3", 600);
        check("t3_wr_words", wr_words, 100);
        check("t3_run0", run_at(0), -64);
        check("t3_run1", run_at(1), -36);

        // EP6 goes full after ten words.
        runs.delete();
        base = in_cnt;
        in_limit = in_cnt + 10;
        send_tx(16'h4000, 15, 1'b0);
        cycles(30);
        check("t4_in_stalled", in_cnt - base, 10);
        check("t4_wr_stalled", wr_words, 110);
        check("t4_tx_ready", tx_ready, 0);
        check("t4_pending", tx_exp.size(), 5);
        in_limit = 1000000;
        drain("t4", 300);
        check("t4_in_done", in_cnt - base, 15);
        check("t4_run0", run_at(0), -10);
        check("t4_run1", run_at(1), -5);

        // Both directions requesting: round-robin bursts.
        runs.delete();
        send_rx(16'h5000, 70);
        send_tx(16'h6000, 70, 1'b0);
        drain("t5", 1500);
        check("t5_run0", run_at(0), 64);
        check("t5_run1", run_at(1), -64);
        check("t5_run2", run_at(2), 6);
        check("t5_run3", run_at(3), -6);
        check("t5_rd_words", rd_words, 95);
        check("t5_wr_words", wr_words, 185);

`ifdef USB_PKTEND_EN
        // Short message commits with PKTEND; a full packet does not.
        base = pkt_pulses;
        send_tx(16'h7000, 10, 1'b1);
        drain("t6a", 300);
        check("t6_short_pulse", pkt_pulses - base, 1);
        send_tx(16'h8000, 256, 1'b1);
        drain("t6b", 1500);
        check("t6_full_nopulse", pkt_pulses - base, 1);
        check("t6_wr_words", wr_words, 451);
`endif

        check("fd_conflicts", conflicts, 0);
        check("fifoadr_errors", addr_err, 0);
        check("tx_ready_no_space", rdy_err, 0);
        check("slwr_handshake", hs_err, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
